// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay frame-buffer writer: stream field
// layout and the frame-pacing state encoding.
package overlay_pkg;

    localparam int STREAM_W  = 54;
    localparam int BE_MSB    = 53;
    localparam int BE_LSB    = 50;
    localparam int FRAME_BIT = 49;
    localparam int ADDR_MSB  = 48;
    localparam int ADDR_LSB  = 32;
    localparam int PIXEL_MSB = 31;
    localparam int PIXEL_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        ACK   = 3'd4
    } state_t;

endpackage

// File: rtl/overlay_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// data_o whenever empty_o is low; a push into a full FIFO is dropped even
// if a pop happens in the same cycle.
module overlay_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer values for accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/overlay_fb_writer.sv
// Overlay frame-buffer writer: buffers the overlay pixel stream, turns each
// entry into a posted byte-masked memory write, and paces the generator one
// frame per display vsync, flipping display_frame once all writes drained.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid never waits on ready, and once a request is valid its
// fields stay unchanged until the transfer. start is held until start_ack.
module overlay_fb_writer import overlay_pkg::*; #(
    parameter int          MAX_ADDR   = 29999,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vsync,
    output logic                start,
    input  logic                start_ack,
    input  logic                in_done,
    output logic                in_done_ack,
    input  logic [STREAM_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    output logic                display_frame,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic [7:0]          overrun_count,
    output state_t              dbg_state_o
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("overlay_fb_writer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (MAX_ADDR < 0 || MAX_ADDR >= (1 << (ADDR_MSB - ADDR_LSB + 1))) begin : g_bad_max
        $error("overlay_fb_writer: MAX_ADDR does not fit the stream address field");
    end

    state_t              state_q, state_d;
    logic                vsync_q, vsync_qq, vsync_rise;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [STREAM_W-1:0] head;
    logic [3:0]          head_be;
    logic                head_frame;
    logic [16:0]         head_addr;
    logic [31:0]         head_pixel;
    logic                last_frame_q;
    logic                display_frame_q;
    logic [15:0]         frame_count_q;
    logic [7:0]          overrun_count_q;

    assign head_be    = head[BE_MSB:BE_LSB];
    assign head_frame = head[FRAME_BIT];
    assign head_addr  = head[ADDR_MSB:ADDR_LSB];
    assign head_pixel = head[PIXEL_MSB:PIXEL_LSB];

    // Stream side: accept whenever there is room, regardless of frame state.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    // Memory side: empty byte masks are discarded without a request.
    assign mem_req_valid = !fifo_empty && (head_be != 4'd0);
    assign fifo_pop      = !fifo_empty && ((head_be == 4'd0) || mem_req_ready);
    assign mem_addr      = BASE_ADDR + {12'd0, head_frame, head_addr, 2'b00};
    assign mem_wdata     = head_pixel;
    assign mem_be        = head_be;

    overlay_fifo #(
        .WIDTH (STREAM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (in_data),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // vsync is registered once, then edge-detected on the registered copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
        end
    end
    assign vsync_rise = vsync_q && !vsync_qq;

    // Frame-pacing state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs for frame pacing.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        in_done_ack = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE:  if (vsync_rise) state_d = START;
            START: begin
                start = 1'b1;
                if (start_ack) state_d = RUN;
            end
            RUN:   if (in_done) state_d = DRAIN;
            DRAIN: if (fifo_empty && !mem_req_valid) state_d = ACK;
            ACK: begin
                in_done_ack = 1'b1;
                frame_done  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame bookkeeping: last popped buffer, displayed buffer and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_frame_q    <= 1'b0;
            display_frame_q <= 1'b0;
            frame_count_q   <= 16'd0;
            overrun_count_q <= 8'd0;
        end else begin
            if (fifo_pop) last_frame_q <= head_frame;
            if (state_q == ACK) begin
                display_frame_q <= last_frame_q;
                frame_count_q   <= frame_count_q + 16'd1;
            end
            if (vsync_rise && state_q != IDLE && overrun_count_q != 8'hFF)
                overrun_count_q <= overrun_count_q + 8'd1;
        end
    end

    assign display_frame = display_frame_q;
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_overlay_fb_writer.sv
// Bench for overlay_fb_writer: directed stream vectors with hand-computed
// write addresses, a write scoreboard fed at issue time and drained by a
// memory-side monitor, plus direct checks of pacing and counters.
module tb_overlay_fb_writer;
    import overlay_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, vsync, start, start_ack, in_done, in_done_ack;
    logic [53:0] in_data;
    logic        in_valid, in_ready, mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        display_frame, frame_done;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;
    state_t      dbg_state;

    overlay_fb_writer dut (
        .clock         (clock),
        .reset         (reset),
        .vsync         (vsync),
        .start         (start),
        .start_ack     (start_ack),
        .in_done       (in_done),
        .in_done_ack   (in_done_ack),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .display_frame (display_frame),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          hs_cnt   = 0;
    int          accepted_cnt = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic [67:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one stream word; the expected write (if any) is queued at issue.
    task automatic send_word(input logic [3:0] be, input logic frame,
                             input logic [16:0] addr, input logic [31:0] pix,
                             input logic [31:0] exp_addr, input bit expect_write);
        logic acc;
        acc = 1'b0;
        if (expect_write && be != 4'd0) exp_q.push_back({exp_addr, pix, be});
        in_data  = {be, frame, addr, pix};
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (acc) accepted_cnt++;
        else begin
            chk_cnt++;
            $display("FAIL stream_accept: word addr %0d never accepted", addr);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check("drain", 68'(exp_q.size()), 68'd0);
    endtask

    task automatic wait_ack();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_done_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 68'(got), 68'd1);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b0;
        tick(); tick();
        vsync = 1'b1;
        tick(); tick();
    endtask

    // ---------------- memory-side monitor ----------------
    logic        stall_prev = 1'b0;
    logic [67:0] held;
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 68'(mem_req_valid), 68'd1);
                check("stall_stable", {mem_addr, mem_wdata, mem_be}, held);
            end
            if (mem_req_valid && mem_req_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL write: unexpected write addr 0x%0h data 0x%0h be 0x%0h",
                             mem_addr, mem_wdata, mem_be);
                end else begin
                    check("write", {mem_addr, mem_wdata, mem_be}, exp_q.pop_front());
                end
            end
            stall_prev = mem_req_valid && !mem_req_ready;
            held       = {mem_addr, mem_wdata, mem_be};
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int h0;
        reset = 1'b1; vsync = 1'b0; start_ack = 1'b0; in_done = 1'b0;
        in_data = '0; in_valid = 1'b0; mem_req_ready = 1'b0;
        repeat (3) tick();
        check("rst_start", 68'(start), 68'd0);
        check("rst_in_done_ack", 68'(in_done_ack), 68'd0);
        check("rst_req_valid", 68'(mem_req_valid), 68'd0);
        check("rst_display_frame", 68'(display_frame), 68'd0);
        check("rst_frame_done", 68'(frame_done), 68'd0);
        check("rst_frame_count", 68'(frame_count), 68'd0);
        check("rst_overrun", 68'(overrun_count), 68'd0);
        check("rst_in_ready", 68'(in_ready), 68'd1);
        check("rst_state", 68'(dbg_state), 68'(IDLE));
        reset = 1'b0;
        tick();

        // vsync -> start two cycles later, held until start_ack
        vsync = 1'b1;
        tick(); check("start_c1", 68'(start), 68'd0);
        tick(); check("start_c2", 68'(start), 68'd1);
        tick(); tick(); check("start_held", 68'(start), 68'd1);
        start_ack = 1'b1;
        tick(); check("start_drop", 68'(start), 68'd0);
        start_ack = 1'b0;
        check("state_run", 68'(dbg_state), 68'(RUN));

        // single write: base + (1<<19) + 5*4
        mem_req_ready = 1'b1;
        send_word(4'hF, 1'b1, 17'd5, 32'hA0A1_A2A3, 32'h1008_0014, 1'b1);
        check("req_valid_next", 68'(mem_req_valid), 68'd1);
        wait_drain();

        // backpressure: 6 words offered while memory stalls for 10 cycles
        mem_req_ready = 1'b0;
        a0 = accepted_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_word(4'hF, 1'b0, 17'(100 + i), 32'hB000_0000 + 32'(i),
                              32'h1000_0190 + 32'(4 * i), 1'b1);
            end
            begin
                repeat (10) tick();
                check("accepted_stall", 68'(accepted_cnt - a0), 68'd4);
                check("in_ready_full", 68'(in_ready), 68'd0);
                mem_req_ready = 1'b1;
            end
        join
        wait_drain();

        // be=0 word among three -> two requests
        h0 = hs_cnt;
        send_word(4'hF, 1'b0, 17'd10, 32'hC0C0_C0C0, 32'h1000_0028, 1'b1);
        send_word(4'h0, 1'b0, 17'd11, 32'hC1C1_C1C1, 32'h1000_002C, 1'b1);
        send_word(4'h3, 1'b0, 17'd12, 32'hC2C2_C2C2, 32'h1000_0030, 1'b1);
        wait_drain();
        repeat (3) tick();
        check("be0_requests", 68'(hs_cnt - h0), 68'd2);

        // in_done with three writes pending in frame 1
        mem_req_ready = 1'b0;
        send_word(4'hF, 1'b1, 17'd20, 32'hD0D0_D0D0, 32'h1008_0050, 1'b1);
        send_word(4'hC, 1'b1, 17'd21, 32'hD1D1_D1D1, 32'h1008_0054, 1'b1);
        send_word(4'h1, 1'b1, 17'd22, 32'hD2D2_D2D2, 32'h1008_0058, 1'b1);
        in_done = 1'b1;
        fork
            begin
                repeat (5) tick();
                check("no_early_ack", 68'(in_done_ack), 68'd0);
                mem_req_ready = 1'b1;
            end
            begin
                wait_ack();
                check("ack_after_last_hs", 68'(cyc > last_hs_cyc), 68'd1);
                check("pending_at_ack", 68'(exp_q.size()), 68'd0);
                check("frame_done_with_ack", 68'(frame_done), 68'd1);
            end
        join
        in_done = 1'b0;
        tick();
        check("frame_done_pulse", 68'(frame_done), 68'd0);
        check("ack_pulse", 68'(in_done_ack), 68'd0);
        check("display_frame_flip", 68'(display_frame), 68'd1);
        check("frame_count_1", 68'(frame_count), 68'd1);

        // new frame, then overruns during RUN
        vsync = 1'b0;
        tick(); tick();
        vsync = 1'b1;
        tick(); tick();
        check("start_frame2", 68'(start), 68'd1);
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        check("no_overrun_from_idle", 68'(overrun_count), 68'd0);
        repeat (3) vsync_pulse();
        check("overrun_3", 68'(overrun_count), 68'd3);
        repeat (297) vsync_pulse();
        check("overrun_sat", 68'(overrun_count), 68'd255);
        vsync = 1'b0;
        tick(); tick();
        in_done = 1'b1;
        wait_ack();
        in_done = 1'b0;
        tick();
        check("frame_count_2", 68'(frame_count), 68'd2);
        check("display_frame_keep", 68'(display_frame), 68'd1);

        // reset mid-frame with writes pending
        vsync = 1'b1;
        tick(); tick();
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        mem_req_ready = 1'b0;
        send_word(4'hF, 1'b0, 17'd30, 32'hE0E0_E0E0, 32'h1000_0078, 1'b0);
        send_word(4'hF, 1'b0, 17'd31, 32'hE1E1_E1E1, 32'h1000_007C, 1'b0);
        check("pending_before_reset", 68'(mem_req_valid), 68'd1);
        h0 = hs_cnt;
        reset = 1'b1;
        tick();
        check("mid_rst_req_valid", 68'(mem_req_valid), 68'd0);
        check("mid_rst_in_ready", 68'(in_ready), 68'd1);
        check("mid_rst_frame_count", 68'(frame_count), 68'd0);
        check("mid_rst_overrun", 68'(overrun_count), 68'd0);
        check("mid_rst_display", 68'(display_frame), 68'd0);
        check("mid_rst_state", 68'(dbg_state), 68'(IDLE));
        reset = 1'b0;
        mem_req_ready = 1'b1;
        repeat (5) tick();
        check("flushed_no_writes", 68'(hs_cnt - h0), 68'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
